// File: rtl/door_pkg.sv
// Shared types and default stroke/dwell constants for the door motion controller.
package door_pkg;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        OPENING = 3'd1,
        OPEN    = 3'd2,
        CLOSING = 3'd3
    } door_state_t;

    localparam int DOOR_TRAVEL  = 8;
    localparam int DOOR_HOLD    = 16;
    localparam int DOOR_MAX_REV = 3;

endpackage

// File: rtl/door_hold_timer.sv
// Loadable down-counter for the OPEN dwell time; expire flags the last dwell cycle.
module door_hold_timer
    import door_pkg::*;
#(
    parameter int  HOLD_CYCLES = DOOR_HOLD,
    localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             expire
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Dwell counter: load has priority over decrement; caller gates en at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= CNT_LOAD;
        end else if (en) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt    = cnt_r;
    assign expire = (cnt_r == CNT_ONE);

endmodule

// File: rtl/door_motion_ctrl.sv
// Door actuator controller: timed open/close strokes, auto-close after a dwell,
// reversal on obstruction with a sticky fault after too many consecutive reversals.
module door_motion_ctrl
    import door_pkg::*;
#(
    parameter int  TRAVEL_CYCLES = DOOR_TRAVEL,
    parameter int  HOLD_CYCLES   = DOOR_HOLD,
    parameter int  MAX_REVERSALS = DOOR_MAX_REV,
    localparam int POS_W         = $clog2(TRAVEL_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             open_req,
    input  logic             close_req,
    input  logic             obstruct,
    output logic             is_open,
    output logic             is_closed,
    output logic             moving,
    output logic [POS_W-1:0] position,
    output logic             fault
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int REV_W  = $clog2(MAX_REVERSALS + 1);

    localparam logic [POS_W-1:0] POS_FULL = POS_W'(TRAVEL_CYCLES);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [REV_W-1:0] REV_MAX  = REV_W'(MAX_REVERSALS);
    localparam logic [REV_W-1:0] REV_ONE  = REV_W'(1);

    door_state_t       state_r;
    logic [POS_W-1:0]  position_r;
    logic [REV_W-1:0]  rev_cnt_r;
    logic              fault_r;

    logic [HOLD_W-1:0] hold_cnt_s;
    logic              hold_expire_s;
    logic              hold_load_s;
    logic              hold_en_s;
    logic              arriving_s;
    logic              close_go_s;

    // >= keeps position clamped even if a reversal happens at the fully-open point
    assign arriving_s  = (state_r == OPENING) && (position_r >= (POS_FULL - POS_ONE));
    assign hold_load_s = arriving_s || ((state_r == OPEN) && (obstruct || open_req));
    assign hold_en_s   = (state_r == OPEN) && (hold_cnt_s != {HOLD_W{1'b0}});
    assign close_go_s  = (close_req || hold_expire_s) && !obstruct && !open_req && !fault_r;

    door_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk    (clk),
        .reset  (reset),
        .load   (hold_load_s),
        .en     (hold_en_s),
        .cnt    (hold_cnt_s),
        .expire (hold_expire_s)
    );

    // Door FSM with position, reversal count and sticky fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= CLOSED;
            position_r <= {POS_W{1'b0}};
            rev_cnt_r  <= {REV_W{1'b0}};
            fault_r    <= 1'b0;
        end else begin
            case (state_r)
                CLOSED: begin
                    if (open_req) begin
                        state_r <= OPENING;
                    end
                end
                OPENING: begin
                    if (arriving_s) begin
                        position_r <= POS_FULL;
                        state_r    <= OPEN;
                    end else begin
                        position_r <= position_r + POS_ONE;
                    end
                end
                OPEN: begin
                    if (close_go_s) begin
                        state_r <= CLOSING;
                    end
                end
                CLOSING: begin
                    if (obstruct) begin
                        state_r <= OPENING;
                        if (rev_cnt_r != REV_MAX) begin
                            rev_cnt_r <= rev_cnt_r + REV_ONE;
                        end
                        if ((rev_cnt_r + REV_ONE) == REV_MAX) begin
                            fault_r <= 1'b1;
                        end
                    end else if (open_req) begin
                        state_r <= OPENING;
                    end else if (position_r <= POS_ONE) begin
                        position_r <= {POS_W{1'b0}};
                        rev_cnt_r  <= {REV_W{1'b0}};
                        state_r    <= CLOSED;
                    end else begin
                        position_r <= position_r - POS_ONE;
                    end
                end
                default: begin
                    state_r    <= CLOSED;
                    position_r <= {POS_W{1'b0}};
                end
            endcase
        end
    end

    assign is_open   = (state_r == OPEN);
    assign is_closed = (state_r == CLOSED);
    assign moving    = (state_r == OPENING) || (state_r == CLOSING);
    assign position  = position_r;
    assign fault     = fault_r;

endmodule

// File: tb/tb_door_motion_ctrl.sv
// Bench for door_motion_ctrl: fixed vector table, directed corner sequences and
// random stimulus against a position/direction reference model.
module tb_door_motion_ctrl;
    import door_pkg::*;

    localparam int T     = DOOR_TRAVEL;
    localparam int H     = DOOR_HOLD;
    localparam int MAXR  = DOOR_MAX_REV;
    localparam int POS_W = $clog2(T + 1);
    localparam int NVEC  = 20;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             open_req = 1'b0;
    logic             close_req = 1'b0;
    logic             obstruct = 1'b0;
    logic             is_open;
    logic             is_closed;
    logic             moving;
    logic [POS_W-1:0] position;
    logic             fault;

    int total = 0;
    int bad   = 0;

    // Reference model: door is at m_pos, travelling in direction m_dir (+1/-1/0).
    int m_pos   = 0;
    int m_dir   = 0;
    int m_hold  = 0;
    int m_revs  = 0;
    bit m_fault = 1'b0;

    typedef struct {
        bit r, o, c, b;
        bit eo, ec, em;
        int ep;
        bit ef;
    } vec_t;

    vec_t tbl [NVEC];

    door_motion_ctrl #(
        .TRAVEL_CYCLES (T),
        .HOLD_CYCLES   (H),
        .MAX_REVERSALS (MAXR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .open_req  (open_req),
        .close_req (close_req),
        .obstruct  (obstruct),
        .is_open   (is_open),
        .is_closed (is_closed),
        .moving    (moving),
        .position  (position),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit o, bit c, bit b, bit eo, bit ec, bit em, int ep, bit ef);
        vec_t v;
        v.r = r; v.o = o; v.c = c; v.b = b;
        v.eo = eo; v.ec = ec; v.em = em; v.ep = ep; v.ef = ef;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit o, input bit c, input bit b);
        if (r) begin
            m_pos = 0; m_dir = 0; m_hold = 0; m_revs = 0; m_fault = 1'b0;
        end else if (m_dir == 1) begin
            m_pos = (m_pos + 1 > T) ? T : m_pos + 1;
            if (m_pos == T) begin
                m_dir = 0;
                m_hold = H;
            end
        end else if (m_dir == -1) begin
            if (b) begin
                m_dir = 1;
                m_revs = (m_revs + 1 > MAXR) ? MAXR : m_revs + 1;
                if (m_revs == MAXR) m_fault = 1'b1;
            end else if (o) begin
                m_dir = 1;
            end else begin
                m_pos = m_pos - 1;
                if (m_pos == 0) begin
                    m_dir = 0;
                    m_revs = 0;
                end
            end
        end else if (m_pos == 0) begin
            if (o) m_dir = 1;
        end else begin
            if (b || o) begin
                m_hold = H;
            end else begin
                if ((c || m_hold == 1) && !m_fault) m_dir = -1;
                m_hold = (m_hold > 0) ? m_hold - 1 : 0;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit o, input bit c, input bit b);
        reset = r; open_req = o; close_req = c; obstruct = b;
        @(posedge clk);
        model_step(r, o, c, b);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_is_open"},   int'(is_open),   int'(m_dir == 0 && m_pos == T));
        chk({tag, "_is_closed"}, int'(is_closed), int'(m_dir == 0 && m_pos == 0));
        chk({tag, "_moving"},    int'(moving),    int'(m_dir != 0));
        chk({tag, "_position"},  int'(position),  m_pos);
        chk({tag, "_fault"},     int'(fault),     int'(m_fault));
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            check_model(tag);
        end
    endtask

    initial begin
        int n;
        int cnt_open;

        // Vector table: open stroke, close, reversal at position 5, open-wins-over-close.
        tbl[0] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[1] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 2; i <= 8; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 1, i - 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 1, 0, 0, 8, 0);
        tbl[10] = mk(0, 0, 1, 0, 0, 0, 1, 8, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 7, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 6, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 5, 0);
        tbl[14] = mk(0, 0, 0, 1, 0, 0, 1, 5, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 6, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 7, 0);
        tbl[17] = mk(0, 0, 0, 0, 1, 0, 0, 8, 0);
        tbl[18] = mk(0, 1, 1, 0, 1, 0, 0, 8, 0);
        tbl[19] = mk(0, 0, 1, 0, 0, 0, 1, 8, 0);

        for (int i = 0; i < NVEC; i++) begin
            cycle(tbl[i].r, tbl[i].o, tbl[i].c, tbl[i].b);
            chk($sformatf("tbl%0d_is_open", i),   int'(is_open),   int'(tbl[i].eo));
            chk($sformatf("tbl%0d_is_closed", i), int'(is_closed), int'(tbl[i].ec));
            chk($sformatf("tbl%0d_moving", i),    int'(moving),    int'(tbl[i].em));
            chk($sformatf("tbl%0d_position", i),  int'(position),  tbl[i].ep);
            chk($sformatf("tbl%0d_fault", i),     int'(fault),     int'(tbl[i].ef));
        end

        // Stroke and dwell timing: open latency, auto-close dwell, close latency.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_model("t1_rst");
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_model("t1_req");
        n = 0;
        do begin cycle(1'b0, 1'b0, 1'b0, 1'b0); check_model("t1_up"); n++; end
        while (!is_open && n < 20);
        chk("open_latency", n, T);
        n = 0;
        do begin cycle(1'b0, 1'b0, 1'b0, 1'b0); check_model("t1_dwell"); n++; end
        while (!moving && n < 40);
        chk("hold_time", n, H);
        n = 0;
        do begin cycle(1'b0, 1'b0, 1'b0, 1'b0); check_model("t1_down"); n++; end
        while (!is_closed && n < 20);
        chk("close_time", n, T);

        // Three obstructed closings latch the fault; door then stays open.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(T, "t4_up");
        chk("t4_opened", int'(is_open), 1);
        for (int r = 0; r < 3; r++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            check_model("t4_close");
            idle(2, "t4_down");
            chk($sformatf("t4_fault_pre%0d", r), int'(fault), 0);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            check_model("t4_rev");
            chk($sformatf("t4_fault_post%0d", r), int'(fault), (r == 2) ? 1 : 0);
            chk($sformatf("t4_rev_pos%0d", r), int'(position), T - 2);
            idle(2, "t4_reopen");
        end
        cnt_open = 0;
        for (int i = 0; i < 110; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            if (is_open) cnt_open++;
        end
        chk("t4_stays_open", cnt_open, 110);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_rst_fault", int'(fault), 0);
        chk("t4_rst_closed", int'(is_closed), 1);

        // Open and close together from CLOSED; obstruction holds the door open.
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t5_open_wins", int'(moving), 1);
        chk("t5_open_pos", int'(position), 0);
        idle(T, "t5_up");
        cnt_open = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            if (is_open) cnt_open++;
        end
        chk("t5_obstruct_hold", cnt_open, 40);
        n = 0;
        do begin cycle(1'b0, 1'b0, 1'b0, 1'b0); check_model("t5_dwell"); n++; end
        while (!moving && n < 40);
        chk("t5_release_hold", n, H);

        // Reset mid opening stroke.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4, "t6_up");
        chk("t6_pos4", int'(position), 4);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6_pos", int'(position), 0);
        chk("t6_closed", int'(is_closed), 1);
        chk("t6_open", int'(is_open), 0);
        chk("t6_moving", int'(moving), 0);
        chk("t6_fault", int'(fault), 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0));
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
